seq_chunk_adder: RTL
====================

// Module: seq_chunk_adder
// PURPOSE
//   Parametrised multi-cycle adder/subtractor. Successor to the single-bit half adder.
//   Adds two WIDTH-bit operands CHUNK bits per clock, with carry held between chunks.
//   Valid/ready handshake on both sides. Reports carry-out and signed overflow.
//   Serves as the arithmetic leaf for datapaths that trade latency for area.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; must be >= 2.
//   CHUNK  4   bits added per cycle; must divide WIDTH. NCHUNK = WIDTH/CHUNK.
// PORTS
//   clk        in   1      single clock; all logic on posedge.
//   rst        in   1      synchronous, active-high reset.
//   in_valid   in   1      operands a/b/cin/sub are valid.
//   in_ready   out  1      block accepts operands (high only in IDLE).
//   a          in   WIDTH  operand A.
//   b          in   WIDTH  operand B.
//   cin        in   1      carry-in (add) / borrow-in (sub).
//   sub        in   1      0: a+b+cin; 1: a-b-cin.
//   out_valid  out  1      result valid; held until out_ready.
//   out_ready  in   1      consumer accepts result.
//   sum        out  WIDTH  result.
//   cout       out  1      raw carry out of the MSB (sub: 1 = no borrow).
//   ovf        out  1      signed overflow = carry into MSB XOR carry out of MSB.
// BEHAVIOUR
//   - Reset (rst=1 at posedge): state=IDLE; out_valid=0, sum=0, cout=0, ovf=0.
//     in_ready=0 while rst is high.
//   - FSM states: IDLE -> BUSY -> DONE -> IDLE.
//   - IDLE: in_ready=1.
//     On in_valid&&in_ready: latch a; latch b (b_eff=~b if sub, else b).
//     Latch c0 (cin if sub=0, ~cin if sub=1). Clear the chunk counter. Go to BUSY.
//   - BUSY: each cycle adds chunk k (bits k*CHUNK +: CHUNK) of a and b_eff plus the held carry.
//     Writes the chunk into sum and updates the carry. k increments.
//     At k=NCHUNK-1: capture the carry into the MSB for ovf, then go to DONE.
//   - DONE: out_valid=1. sum, cout and ovf are stable.
//     On out_ready: out_valid drops next cycle and the FSM returns to IDLE.
//   - Latency: accept at edge T gives out_valid=1 after edge T+NCHUNK.
//     Minimum issue interval: NCHUNK+2 cycles. There is no overlap of transactions.
//   - in_ready=0 in BUSY and DONE. in_valid is ignored there, and operands are not re-sampled.
//   - Output backpressure: out_ready=0 holds DONE indefinitely with no change to the outputs.
//   - Reset mid-BUSY or mid-DONE: the result is discarded and out_valid=0 next cycle.
//   - sum/cout/ovf are only meaningful while out_valid=1.
//     They retain their last value after the handshake until the next result.
//   - CHUNK=WIDTH is legal: single BUSY cycle.
// CONFIGURATION
//   SEQ_CHUNK_ADDER_SAT_EN defined: signed saturation on overflow.
//     If ovf=1, sum = a[WIDTH-1] ? {1'b1,{WIDTH-1{1'b0}}} : {1'b0,{WIDTH-1{1'b1}}}.
//     The clamp is applied on entry to DONE. cout and ovf are reported unchanged.
//   Not defined: two's-complement wrap-around; ovf is still reported.
// TESTING (WIDTH=16, CHUNK=4 unless noted)
//   1. a=0x00FF b=0x0001 cin=0 sub=0 -> sum=0x0100 cout=0 ovf=0.
//      out_valid rises exactly 4 cycles after accept.
//   2. a=0xFFFF b=0x0001 cin=0 sub=0 -> sum=0x0000 cout=1 ovf=0.
//      Repeat with cin=1 -> sum=0x0001 cout=1.
//   3. a=0x7FFF b=0x0001 sub=0 -> ovf=1.
//      sum=0x8000 without SAT_EN; sum=0x7FFF with SEQ_CHUNK_ADDER_SAT_EN.
//   4. a=0x0005 b=0x0007 cin=0 sub=1 -> sum=0xFFFE cout=0 ovf=0.
//      a=0x8000 b=0x0001 sub=1 -> ovf=1 (SAT: 0x8000).
//   5. Hold out_ready=0 for 10 cycles after DONE while driving a new in_valid.
//      -> sum stable, in_ready=0, new operands not taken.
//      Release out_ready -> IDLE, then the new operands are accepted.
//   6. Assert rst during the 2nd BUSY cycle.
//      -> next cycle out_valid=0, sum=0; in_ready=1 the cycle after rst drops.
//   Also: random sweep vs a+/-b reference with CHUNK in {1,4,16}, including full-range wrap cases.

Source files
------------

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock with the carry held between chunks.
// Define SEQ_CHUNK_ADDER_SAT_EN to clamp the result to the signed range on overflow.
module seq_chunk_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = $clog2(NCHUNK + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_cout;
   logic             r_ovf;
   logic [KW-1:0]    r_k;

   logic [CHUNK:0]   w_chunk;
   logic [WIDTH-1:0] w_sum_shift;
   logic [WIDTH-1:0] w_a_shift;
   logic [WIDTH-1:0] w_b_shift;
   logic [WIDTH-1:0] w_sum_final;
   logic             w_last;
   logic             w_c_msb;
   logic             w_ovf;

   // Operands shift right one chunk per cycle, so the active chunk always sits in the low bits
   // and result chunks enter r_sum from the top.
   assign w_chunk = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
   assign w_last  = (r_k == KW'(NCHUNK - 1));

   generate
      if (CHUNK == WIDTH) begin : g_single
         assign w_sum_shift = w_chunk[CHUNK-1:0];
         assign w_a_shift   = '0;
         assign w_b_shift   = '0;
      end else begin : g_multi
         assign w_sum_shift = {w_chunk[CHUNK-1:0], r_sum[WIDTH-1:CHUNK]};
         assign w_a_shift   = {{CHUNK{1'b0}}, r_a[WIDTH-1:CHUNK]};
         assign w_b_shift   = {{CHUNK{1'b0}}, r_b[WIDTH-1:CHUNK]};
      end
   endgenerate

   // On the last chunk the operand MSBs are at bit CHUNK-1; sum bit = a ^ b ^ carry-in recovers it.
   assign w_c_msb = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_chunk[CHUNK-1];
   assign w_ovf   = w_c_msb ^ w_chunk[CHUNK];

`ifdef SEQ_CHUNK_ADDER_SAT_EN
   assign w_sum_final = !w_ovf       ? w_sum_shift :
                        r_a[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                       {1'b0, {(WIDTH-1){1'b1}}};
`else
   assign w_sum_final = w_sum_shift;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_k     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= sub ? ~b : b;
                  r_carry <= cin ^ sub;
                  r_k     <= '0;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_a     <= w_a_shift;
               r_b     <= w_b_shift;
               r_carry <= w_chunk[CHUNK];
               r_k     <= r_k + KW'(1);
               if (w_last) begin
                  r_sum   <= w_sum_final;
                  r_cout  <= w_chunk[CHUNK];
                  r_ovf   <= w_ovf;
                  r_state <= S_DONE;
               end else begin
                  r_sum   <= w_sum_shift;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE) && !rst;
   assign out_valid = (r_state == S_DONE);
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;

endmodule
